router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of 9-bit entries; power of two, 4 to 64.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 soft_reset  input  1  synchronous flush from the synchroniser timeout.
REQ-005 write_enb  input  1  write request for data_in this cycle.
REQ-006 read_enb  input  1  read request from the output port consumer.
REQ-007 lfd_state  input  1  marks the data_in word as a packet header; stored as bit 8.
REQ-008 data_in  input  8  byte from the register stage: header, payload or parity.
REQ-009 data_out  output  8  registered read data.
REQ-010 full  output  1  no free entry.
REQ-011 empty  output  1  no valid entry.

Function
REQ-012 Storage: DEPTH x 9 bits, entry = {lfd_state, data_in}; pointers are log2(DEPTH)+1 bits wide with a wrap bit.
REQ-013 full = (wr_ptr MSB != rd_ptr MSB) and (lower bits equal); empty = (wr_ptr == rd_ptr); both combinational from pointers.
REQ-014 Write accepted when write_enb=1 and full=0; entry stored at wr_ptr and wr_ptr increments, wrapping at 2*DEPTH.
REQ-015 Write while full is dropped: no pointer or storage change.
REQ-016 Read accepted when read_enb=1 and empty=0; data_out = stored[7:0] on the next edge (latency 1), rd_ptr increments.
REQ-017 Read while empty is ignored; data_out holds.
REQ-018 Simultaneous accepted read and write both occur; occupancy unchanged; a write while full combined with a read still drops the write (full sampled before the edge).
REQ-019 Packet counter (6+1 bits): reading an entry with bit8=1 loads count = data[7:2] + 1 (payload plus parity).
REQ-020 Each accepted read of a non-header entry decrements the count while it is nonzero; the count never underflows.
REQ-021 When the count is 0 and no read is accepted, data_out is driven to 8'h00 on the next edge, giving an idle-low bus between packets.
REQ-022 soft_reset=1 at an edge clears pointers, counter and data_out to 0 and overrides write_enb and read_enb in that cycle.

Reset
REQ-023 The reset assertion clears wr_ptr, rd_ptr, counter and data_out to 0 without waiting for the clock; full=0 and empty=1 during and after reset.
REQ-024 Storage contents are not reset.
REQ-025 A write_enb or read_enb asserted in the first edge after reset deasserts is honoured.

Configuration
REQ-026 With ROUTER_FIFO_COUNT_EN defined, an extra output fifo_count [log2(DEPTH):0] gives the registered occupancy (0..DEPTH), which is cleared by reset and by soft_reset.
REQ-027 Without ROUTER_FIFO_COUNT_EN, the port and its logic are absent and the rest of the behaviour is identical.

Structure
REQ-028 The shared package router_pkg holds DATA_W=8, the header field positions (ADDR [1:0], LEN [7:2]) and the default FIFO_DEPTH=16.
REQ-029 A single sub-module router_fifo_mem holds the DEPTH x 9 register array, with a synchronous write port and an asynchronous read port; the pointers, flags and counter stay in router_fifo.

Verification
REQ-030 Reset test: assert reset mid-packet with 5 entries present. Required response: empty=1 and full=0 immediately; fifo_count=0; the next read returns nothing.
REQ-031 Packet test: write header 8'h0E (lfd=1, len 3, addr 2'b10), 3 payload bytes and parity, then read 5 times. Required response: the bytes come out in order one cycle after each read_enb, then data_out=8'h00 on the 6th cycle.
REQ-032 Full test: 16 writes give full=1; a 17th write with 8'hAA is dropped; 16 reads return the original data and empty=1.
REQ-033 Simultaneous test: with 16 entries present, assert write_enb and read_enb together. Required response: the read succeeds, the write is dropped, and occupancy becomes 15.
REQ-034 Wrap test: run 40 write/read pairs with data i. Required response: all data matches across the pointer wrap, and full never asserts.
REQ-035 Soft-reset test: pulse soft_reset with 7 entries present and write_enb=1. Required response: empty=1, data_out=8'h00, and that write is lost.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and constants.
// Header byte layout: ADDR in [1:0], LEN in [7:2].
package router_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_MSB   = 1;
  localparam int LEN_LSB    = 2;
  localparam int LEN_MSB    = 7;
  localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;
  localparam int CNT_W      = LEN_W + 1;
  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic logic [LEN_W-1:0] hdr_len(
    input logic [DATA_W-1:0] b
  );
    return b[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Router FIFO port bundle.
// master drives requests, slave is the FIFO.
interface router_fifo_if;
  import router_pkg::*;

  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );

endinterface

// File: rtl/router_fifo_mem.sv
// Router FIFO storage: DEPTH x 9 register array.
// Sync write, async read, no reset on contents.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fifo_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fifo_entry_t rd_data
);

  fifo_entry_t mem [DEPTH];

  // store accepted entry at the write slot
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Router output FIFO with packet-length counter.
// Optional occupancy port: ROUTER_FIFO_COUNT_EN.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic soft_reset,
  router_fifo_if.slave bus
`ifdef ROUTER_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] fifo_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  dout;
  logic               full_i;
  logic               empty_i;
  logic               wr_acc;
  logic               rd_acc;
  fifo_entry_t        wr_entry;
  fifo_entry_t        rd_entry;

  assign full_i  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_i = (wr_ptr == rd_ptr);
  assign wr_acc  = bus.write_enb & ~full_i;
  assign rd_acc  = bus.read_enb & ~empty_i;

  assign wr_entry.hdr  = bus.lfd_state;
  assign wr_entry.data = bus.data_in;

  assign bus.full     = full_i;
  assign bus.empty    = empty_i;
  assign bus.data_out = dout;

  router_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc & ~soft_reset),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_entry)
  );

  // advance pointers on accepted transfers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // read data and packet countdown; bus idles low between packets
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= '0;
    end else if (soft_reset) begin
      cnt  <= '0;
      dout <= '0;
    end else if (rd_acc) begin
      dout <= rd_entry.data;
      if (rd_entry.hdr)
        cnt <= CNT_W'(hdr_len(rd_entry.data)) + CNT_W'(1);
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end else if (cnt == '0) begin
      dout <= '0;
    end
  end

`ifdef ROUTER_FIFO_COUNT_EN
  // registered occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_count <= '0;
    end else if (soft_reset) begin
      fifo_count <= '0;
    end else begin
      unique case (1'b1)
        (wr_acc & ~rd_acc): fifo_count <= fifo_count + (AW+1)'(1);
        (rd_acc & ~wr_acc): fifo_count <= fifo_count - (AW+1)'(1);
        default:            fifo_count <= fifo_count;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed testbench for router_fifo.
// Define ROUTER_FIFO_COUNT_EN to also check fifo_count.
module tb_router_fifo;

  logic clock;
  logic reset;
  logic soft_reset;
  int   checks;
  int   failures;

  router_fifo_if bus();

`ifdef ROUTER_FIFO_COUNT_EN
  logic [4:0] fifo_count;
`endif

  router_fifo #(.DEPTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
`ifdef ROUTER_FIFO_COUNT_EN
    ,
    .fifo_count (fifo_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic h, input logic [7:0] d);
    bus.write_enb = 1'b1;
    bus.lfd_state = h;
    bus.data_in   = d;
    cyc();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic pop();
    bus.read_enb = 1'b1;
    cyc();
    bus.read_enb = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags: got e=%b f=%b want e=1 f=0",
               bus.empty, bus.full);
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL rst_dout: got %h want 00", bus.data_out);
    end
    @(negedge clock);
    reset = 1'b0;
    push(1'b1, 8'h0E);
    checks++;
    if (bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL first_write: got empty=%b want 0", bus.empty);
    end
    for (int i = 1; i <= 5; i++) push(1'b0, 8'(i));
    pop();
    checks++;
    if (bus.data_out !== 8'h0E) begin
      failures++;
      $display("FAIL rst_hdr: got %h want 0e", bus.data_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid: got e=%b f=%b d=%h want 1 0 00",
               bus.empty, bus.full, bus.data_out);
    end
`ifdef ROUTER_FIFO_COUNT_EN
    checks++;
    if (fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL rst_cnt: got %0d want 0", fifo_count);
    end
`endif
    #3 reset = 1'b0;
    pop();
    checks++;
    if (bus.data_out !== 8'h00 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL rst_read: got d=%h e=%b want 00 1",
               bus.data_out, bus.empty);
    end
  endtask

  task automatic test_packet();
    logic [7:0] exp [5];
    exp[0] = 8'h0E;
    exp[1] = 8'h11;
    exp[2] = 8'h22;
    exp[3] = 8'h33;
    exp[4] = 8'h44;
    push(1'b1, exp[0]);
    for (int i = 1; i < 5; i++) push(1'b0, exp[i]);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (bus.data_out !== exp[i]) begin
        failures++;
        $display("FAIL pkt_byte%0d: got %h want %h",
                 i, bus.data_out, exp[i]);
      end
    end
    bus.read_enb = 1'b0;
    cyc();
    checks++;
    if (bus.data_out !== 8'h00 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL pkt_idle: got d=%h e=%b want 00 1",
               bus.data_out, bus.empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h10 + i));
    checks++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL full_set: got f=%b e=%b want 1 0",
               bus.full, bus.empty);
    end
`ifdef ROUTER_FIFO_COUNT_EN
    checks++;
    if (fifo_count !== 5'd16) begin
      failures++;
      $display("FAIL full_cnt: got %0d want 16", fifo_count);
    end
`endif
    push(1'b0, 8'hAA);
    checks++;
    if (bus.full !== 1'b1) begin
      failures++;
      $display("FAIL full_drop: got f=%b want 1", bus.full);
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      checks++;
      if (bus.data_out !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL full_rd%0d: got %h want %h",
                 i, bus.data_out, 8'(8'h10 + i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL full_empty: got e=%b f=%b want 1 0",
               bus.empty, bus.full);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h50 + i));
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'hAA;
    cyc();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    checks++;
    if (bus.data_out !== 8'h50 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL sim_rw: got d=%h f=%b want 50 0",
               bus.data_out, bus.full);
    end
`ifdef ROUTER_FIFO_COUNT_EN
    checks++;
    if (fifo_count !== 5'd15) begin
      failures++;
      $display("FAIL sim_cnt: got %0d want 15", fifo_count);
    end
`endif
    for (int i = 1; i < 16; i++) begin
      pop();
      checks++;
      if (bus.data_out !== 8'(8'h50 + i)) begin
        failures++;
        $display("FAIL sim_rd%0d: got %h want %h",
                 i, bus.data_out, 8'(8'h50 + i));
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL sim_empty: got %b want 1", bus.empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      push(1'b0, 8'(i));
      checks++;
      if (bus.full !== 1'b0) begin
        failures++;
        $display("FAIL wrap_full%0d: got %b want 0", i, bus.full);
      end
      pop();
      checks++;
      if (bus.data_out !== 8'(i)) begin
        failures++;
        $display("FAIL wrap_rd%0d: got %h want %h",
                 i, bus.data_out, 8'(i));
      end
    end
  endtask

  task automatic test_soft_reset();
    push(1'b1, 8'h1C);
    for (int i = 0; i < 7; i++) push(1'b0, 8'(8'h71 + i));
    pop();
    cyc();
    checks++;
    if (bus.data_out !== 8'h1C) begin
      failures++;
      $display("FAIL sr_hold: got %h want 1c", bus.data_out);
    end
    soft_reset    = 1'b1;
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'hEE;
    cyc();
    soft_reset    = 1'b0;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    checks++;
    if (bus.empty !== 1'b1 || bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL sr_clear: got e=%b d=%h want 1 00",
               bus.empty, bus.data_out);
    end
`ifdef ROUTER_FIFO_COUNT_EN
    checks++;
    if (fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL sr_cnt: got %0d want 0", fifo_count);
    end
`endif
    pop();
    checks++;
    if (bus.data_out !== 8'h00 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL sr_lost: got d=%h e=%b want 00 1",
               bus.data_out, bus.empty);
    end
    push(1'b0, 8'h99);
    pop();
    checks++;
    if (bus.data_out !== 8'h99 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL sr_after: got d=%h e=%b want 99 1",
               bus.data_out, bus.empty);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    soft_reset    = 1'b0;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'h00;
    test_reset();
    test_packet();
    test_full();
    test_simul();
    test_wrap();
    test_soft_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
